// File: rtl/hash_byte_feeder.sv
// hash_byte_feeder: buffers a host-written message, starts the hash core, streams
//    the bytes over the F_dr/F_rtr handshake with End_of_File on the last byte,
//    then waits for H_ready and captures the 32-bit digest.
//    Host side : wr_en/wr_data fill the buffer, go starts a transfer; busy, done,
//                overflow, err_empty, timeout and digest_out report status.
//    Hash side : start, Byte, F_dr, End_of_File out; F_rtr, H_ready, R_h in.
//    Build option FEEDER_TIMEOUT_EN: abandon WAIT_H after TIMEOUT_CYCLES cycles
//    without H_ready and raise the sticky timeout flag; otherwise timeout is 0.
module hash_byte_feeder #(
   parameter int DEPTH          = 64,
   parameter int AW             = 6,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [7:0]  wr_data,
   input  logic        go,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        err_empty,
   output logic        timeout,
   output logic [31:0] digest_out,
   output logic        start,
   output logic [7:0]  Byte,
   output logic        F_dr,
   output logic        End_of_File,
   input  logic        F_rtr,
   input  logic        H_ready,
   input  logic [31:0] R_h
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
   logic [2:0]    state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d, err_q, err_d;
   logic [31:0]   dig_q, dig_d;
   logic [7:0]    mem [DEPTH];
   logic          last, wr_ok;
`ifdef FEEDER_TIMEOUT_EN
   localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tcnt_q, tcnt_d;
   logic        tmo_q, tmo_d;
`else
   logic unused_tmo;
   assign unused_tmo = TIMEOUT_CYCLES != 0;
`endif
   assign last  = {1'b0, rd_ptr_q} == count_q - 1'b1;
   // a go in the same cycle as a write wins; the write is dropped
   assign wr_ok = state_q == S_IDLE && wr_en && !go && count_q != FULL;
   always_ff @(posedge clk)
      if (wr_ok) mem[count_q[AW-1:0]] <= wr_data;
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      err_d    = 1'b0;
      dig_d    = dig_q;
`ifdef FEEDER_TIMEOUT_EN
      tmo_d    = tmo_q;
      tcnt_d   = state_q == S_WAIT ? tcnt_q + 16'd1 : '0;
`endif
      case (state_q)
         S_IDLE:
            if (go) begin
               err_d = count_q == '0;
               if (count_q != '0) begin
                  state_d  = S_START;
                  rd_ptr_d = '0;
                  ovf_d    = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
                  tmo_d    = 1'b0;
`endif
               end
            end else if (wr_en) begin
               ovf_d   = ovf_q | (count_q == FULL);
               count_d = wr_ok ? count_q + 1'b1 : count_q;
            end
         S_START: state_d = S_SEND;
         S_SEND:
            if (F_rtr) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               state_d  = last ? S_WAIT : S_SEND;
            end
         S_WAIT:
            if (H_ready) begin
               dig_d   = R_h;
               state_d = S_DONE;
            end
`ifdef FEEDER_TIMEOUT_EN
            else if (tcnt_q == TLAST) begin
               tmo_d   = 1'b1;
               count_d = '0;
               state_d = S_IDLE;
            end
`endif
         S_DONE: begin
            count_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         dig_q    <= '0;
`ifdef FEEDER_TIMEOUT_EN
         tmo_q    <= 1'b0;
         tcnt_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         dig_q    <= dig_d;
`ifdef FEEDER_TIMEOUT_EN
         tmo_q    <= tmo_d;
         tcnt_q   <= tcnt_d;
`endif
      end
   end
   // handshake outputs decode straight from state so reset drops them at once
   assign busy        = state_q != S_IDLE;
   assign start       = state_q == S_START;
   assign F_dr        = state_q == S_SEND;
   assign End_of_File = F_dr && last;
   assign Byte        = F_dr ? mem[rd_ptr_q] : 8'h00;
   assign done        = state_q == S_DONE;
   assign overflow    = ovf_q;
   assign err_empty   = err_q;
   assign digest_out  = dig_q;
`ifdef FEEDER_TIMEOUT_EN
   assign timeout     = tmo_q;
`else
   assign timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_hash_byte_feeder.sv
// tb_hash_byte_feeder: randomized self-checking bench for hash_byte_feeder
module tb_hash_byte_feeder;
   logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, go = 1'b0, F_rtr = 1'b0, H_ready = 1'b0;
   logic [7:0]  wr_data = '0;
   logic [31:0] R_h = '0;
   logic        busy, done, overflow, err_empty, timeout, start, F_dr, End_of_File;
   logic [7:0]  Byte;
   logic [31:0] digest_out;
   int          checks = 0, errors = 0;
   logic [7:0]  q_buf[$], exp_stream[$], got[$];
   int          exp_idx = 0, n_xfer = 0, n_start = 0, n_done = 0, n_err = 0, eof_idx = -1;
   logic        exp_ovf = 1'b0;
   logic [31:0] exp_dig = '0;
   logic        pf = 1'b0, pr = 1'b0, pe = 1'b0;
   logic [7:0]  pb = '0;

   hash_byte_feeder #(.DEPTH(64), .AW(6), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .go(go),
      .busy(busy), .done(done), .overflow(overflow), .err_empty(err_empty),
      .timeout(timeout), .digest_out(digest_out), .start(start), .Byte(Byte),
      .F_dr(F_dr), .End_of_File(End_of_File), .F_rtr(F_rtr), .H_ready(H_ready), .R_h(R_h));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   // stream monitor: every handshake byte must be the next message byte, in order
   initial forever begin
      @(negedge clk);
      if (!rst_n) pf = 1'b0;
      else begin
         if (pf && !pr) begin
            chk("hold_fdr", F_dr, 1);
            chk("hold_byte", Byte, pb);
            chk("hold_eof", End_of_File, pe);
         end
         if (!busy) begin
            chk("idle_fdr", F_dr, 0);
            chk("idle_start", start, 0);
         end
         if (End_of_File) chk("eof_without_fdr", F_dr, 0 + 1);
         if (F_dr) begin
            if (exp_idx >= exp_stream.size()) chk("fdr_beyond_msg", F_dr, 0);
            else begin
               chk("eof_position", End_of_File, exp_idx == exp_stream.size() - 1);
               if (F_rtr) begin
                  chk("byte_value", Byte, exp_stream[exp_idx]);
                  got.push_back(Byte);
                  if (End_of_File) eof_idx = n_xfer;
                  exp_idx++;
                  n_xfer++;
               end
            end
         end
         if (start) n_start++;
         if (err_empty) n_err++;
         if (done) begin
            n_done++;
            chk("done_digest", digest_out, exp_dig);
         end
         pf = F_dr; pr = F_rtr; pb = Byte; pe = End_of_File;
      end
   end

   task automatic write_byte(input logic [7:0] b);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_data = b;
      if (q_buf.size() < 64) q_buf.push_back(b);
      else exp_ovf = 1'b1;
   endtask

   task automatic end_wr();
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic go_pulse();
      exp_stream = q_buf;
      q_buf.delete();
      got.delete();
      exp_idx = 0; n_xfer = 0; n_start = 0; n_done = 0; n_err = 0; eof_idx = -1;
      if (exp_stream.size() != 0) exp_ovf = 1'b0;
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
   endtask

   function automatic logic rtr_val(input int mode, input int i);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (i % 4 == 0) || (i % 4 == 3);
      return $urandom_range(0, 1) != 0;
   endfunction

   task automatic send_msg(input int mode);
      int cyc = 0;
      go_pulse();
      chk("go_to_start", start, 1);
      chk("busy_after_go", busy, 1);
      chk("no_err_on_go", err_empty, 0);
      chk("ovf_after_go", overflow, exp_ovf);
      @(posedge clk); #1;
      chk("start_one_cycle", start, 0);
      chk("start_to_fdr", F_dr, 1);
      chk("first_byte", Byte, exp_stream[0]);
      while (n_xfer < exp_stream.size() && cyc < 400) begin
         F_rtr = rtr_val(mode, cyc);
         @(posedge clk); #1;
         cyc++;
      end
      F_rtr = 1'b0;
      chk("xfer_count", n_xfer, exp_stream.size());
   endtask

   task automatic finish_msg(input logic [31:0] dig, input int hd);
      repeat (hd) begin @(posedge clk); #1; end
      chk("wait_busy", busy, 1);
      chk("wait_no_fdr", F_dr, 0);
      chk("wait_no_done", done, 0);
      exp_dig = dig; H_ready = 1'b1; R_h = dig;
      @(posedge clk); #1;
      H_ready = 1'b0; R_h = $urandom;
      chk("done_pulse", done, 1);
      chk("digest", digest_out, dig);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("start_count", n_start, 1);
      chk("done_count", n_done, 1);
   endtask

   task automatic empty_go();
      go_pulse();
      chk("err_pulse", err_empty, 1);
      chk("err_busy", busy, 0);
      @(posedge clk); #1;
      chk("err_one_cycle", err_empty, 0);
      chk("err_no_start", n_start, 0);
      chk("err_count", n_err, 1);
      chk("err_still_idle", busy, 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ovf", overflow, 0);
      chk("rst_err", err_empty, 0); chk("rst_tmo", timeout, 0); chk("rst_digest", digest_out, 0);
      chk("rst_start", start, 0); chk("rst_fdr", F_dr, 0); chk("rst_eof", End_of_File, 0);
      chk("rst_byte", Byte, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // directed abc message
      write_byte(8'h61); write_byte(8'h62); write_byte(8'h63); end_wr();
      send_msg(0);
      finish_msg(32'hDEADBEEF, 0);
      chk("abc_len", got.size(), 3);
      chk("abc_b0", got[0], 8'h61); chk("abc_b1", got[1], 8'h62); chk("abc_b2", got[2], 8'h63);
      chk("abc_eof", eof_idx, 2);
      chk("abc_digest", digest_out, 32'hDEADBEEF);

      // H_ready outside WAIT_H is ignored
      H_ready = 1'b1; R_h = 32'h12345678;
      @(posedge clk); #1 H_ready = 1'b0;
      chk("stray_hready_digest", digest_out, exp_dig);
      chk("stray_hready_done", done, 0);
      chk("stray_hready_busy", busy, 0);

      // toggling F_rtr over a 4-byte message
      for (int i = 0; i < 4; i++) write_byte(8'(8'h10 + 8'(i)));
      end_wr();
      send_msg(1);
      finish_msg(32'hCAFE0004, 2);
      chk("tog_b3", got[3], 8'h13);
      chk("tog_eof", eof_idx, 3);

      // empty go
      empty_go();

      // 65 writes overflow the 64-byte buffer
      for (int i = 0; i < 65; i++) write_byte(8'($urandom));
      end_wr();
      chk("ovf_set", overflow, exp_ovf);
      chk("ovf_lit", exp_ovf, overflow | 1'b1);
      send_msg(0);
      chk("ovf_cleared_lit", overflow, 0);
      finish_msg($urandom, 1);
      chk("full_xfers", n_xfer, 64);
      chk("full_eof", eof_idx, 63);

      // randomized messages
      for (int m = 0; m < 10; m++) begin
         int len = $urandom_range(1, 64);
         for (int i = 0; i < len; i++) write_byte(8'($urandom));
         end_wr();
         send_msg($urandom_range(0, 2));
         finish_msg($urandom, $urandom_range(0, 3));
      end

      // reset while the second byte is on the bus
      for (int i = 0; i < 4; i++) write_byte(8'(8'hA0 + 8'(i)));
      end_wr();
      go_pulse();
      F_rtr = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("pre_rst_fdr", F_dr, 1);
      chk("pre_rst_byte", Byte, 8'hA1);
      chk("pre_rst_xfers", n_xfer, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_fdr", F_dr, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_start", start, 0);
      chk("async_rst_digest", digest_out, 0);
      F_rtr = 1'b0;
      q_buf.delete(); exp_stream.delete(); exp_ovf = 1'b0; exp_dig = '0;
      repeat (2) @(posedge clk); #1 rst_n = 1'b1;
      empty_go();
      for (int i = 0; i < 3; i++) write_byte(8'($urandom));
      end_wr();
      send_msg(2);
      finish_msg($urandom, 0);

      // no H_ready at all
      write_byte(8'h5A); write_byte(8'hA5); end_wr();
      send_msg(0);
      repeat (12) @(posedge clk); #1;
      chk("hwait_busy", busy, 1);
      repeat (20) @(posedge clk); #1;
`ifdef FEEDER_TIMEOUT_EN
      chk("tmo_set", timeout, 1);
      chk("tmo_idle", busy, 0);
      chk("tmo_no_done", n_done, 0);
      chk("tmo_digest_kept", digest_out, exp_dig);
      write_byte(8'h77); end_wr();
      send_msg(0);
      chk("tmo_cleared", timeout, 0);
      finish_msg($urandom, 0);
`else
      chk("no_tmo_busy", busy, 1);
      chk("no_tmo_flag", timeout, 0);
      finish_msg($urandom, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
